// File: rtl/avalon_fifo_slave.sv
// Avalon-MM slave exposing a 32-bit FIFO (push, status, control, head-peek registers)
// that drains through a valid/ready stream port; reads answer after a fixed latency.
module avalon_fifo_slave #(
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic        readdatavalid,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_HEAD    = 2'd3;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] thresh_q, thresh_d;
  logic          irqEn_q, irqEn_d;
  logic          irq_q;

  logic [READ_LATENCY-1:0] rdValid_q, rdValid_d;
  logic [31:0]             rdData_q [READ_LATENCY];
  logic [31:0]             rdData_d [READ_LATENCY];

  logic [1:0]  regSel;
  logic        empty, full, rdBusy;
  logic        wrAccept, rdAccept;
  logic        push, pop, ctrlWrite, flush;
  logic [31:0] regValue;
  logic        unused_addrBits;

  assign regSel          = address[3:2];
  assign unused_addrBits = ^{address[31:4], address[1:0]};

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign rdBusy = |rdValid_q;

  // Only one read may be in flight; a full FIFO stalls pushes even if a pop lands this cycle.
  assign waitrequest = rdBusy | (write & (regSel == REG_DATA) & full);

  assign wrAccept  = write & ~waitrequest;
  assign rdAccept  = read & ~waitrequest;
  assign push      = wrAccept & (regSel == REG_DATA);
  assign ctrlWrite = wrAccept & (regSel == REG_CONTROL);
  assign flush     = ctrlWrite & writedata[0];
  assign pop       = ~empty & out_ready;

  always_comb begin
    rdPtr_d  = rdPtr_q;
    wrPtr_d  = wrPtr_q;
    count_d  = count_q;
    irqEn_d  = irqEn_q;
    thresh_d = thresh_q;
    if (ctrlWrite) begin
      irqEn_d  = writedata[1];
      thresh_d = writedata[8 +: CW];
    end
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      if (push) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    regValue = '0;
    case (regSel)
      REG_STATUS: begin
        regValue[0]       = empty;
        regValue[1]       = full;
        regValue[8 +: CW] = count_q;
      end
      REG_CONTROL: begin
        regValue[1]       = irqEn_q;
        regValue[8 +: CW] = thresh_q;
      end
      REG_HEAD: begin
        if (!empty) begin
          regValue = mem[rdPtr_q];
        end
      end
      default: regValue = '0;
    endcase
  end

  // Read pipeline: stage 0 captures the register value at acceptance, later stages shift it on.
  always_comb begin
    rdValid_d[0] = rdAccept;
    rdData_d[0]  = regValue;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rdValid_d[i] = rdValid_q[i-1];
      rdData_d[i]  = rdData_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      thresh_q  <= '0;
      irqEn_q   <= 1'b0;
      irq_q     <= 1'b0;
      rdValid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        rdData_q[i] <= '0;
      end
    end else begin
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      thresh_q  <= thresh_d;
      irqEn_q   <= irqEn_d;
      irq_q     <= irqEn_q & (count_q >= thresh_q) & ~empty;
      rdValid_q <= rdValid_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        if (rdValid_d[i]) begin
          rdData_q[i] <= rdData_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr_q] <= writedata;
    end
  end

  assign readdatavalid = rdValid_q[READ_LATENCY-1];
  assign readdata      = rdData_q[READ_LATENCY-1];
  assign out_valid     = ~empty;
  assign out_data      = empty ? '0 : mem[rdPtr_q];
  assign irq           = irq_q;

endmodule

// File: tb/tb_avalon_fifo_slave.sv
// Self-checking bench for avalon_fifo_slave: a cycle table, directed corner sequences,
// and randomized traffic compared against a queue-based model of the register map.
module tb_avalon_fifo_slave;

  localparam int DEPTH = 16;
  localparam int L     = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address;
  logic        write, read;
  logic [31:0] writedata;
  logic        waitrequest, readdatavalid;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid, out_ready, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_fifo_slave #(.DEPTH(DEPTH), .READ_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write), .read(read),
    .writedata(writedata), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .irq(irq)
  );

  typedef struct {
    logic        wr, rd;
    logic [1:0]  r;
    logic [31:0] wd;
    logic        rdy;
    logic        eWait, eRdv;
    logic [31:0] eRdata;
    logic        eOv;
    logic [31:0] eOd;
    logic        eIrq;
  } vec_t;

  vec_t tbl [26];

  // Behavioural model state
  logic [31:0] mq [$];
  logic        mIrqEn, mIrq, mPend;
  int          mThresh, mAge;
  logic [31:0] mVal, mRdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, return at the following falling edge.
  task automatic applyStimulus(input int wr, input int rd, input int r, input logic [31:0] wd, input int rdy);
    logic [31:0] a;
    @(posedge clk);
    #1;
    a         = $urandom();
    a[3:2]    = 2'(r);
    address   = a;
    write     = (wr != 0);
    read      = (rd != 0);
    writedata = wd;
    out_ready = (rdy != 0);
    @(negedge clk);
  endtask

  function automatic vec_t mk(int wr, int rd, int r, logic [31:0] wd, int rdy,
                              int eW, int eV, logic [31:0] eD, int eO, logic [31:0] eOd, int eI);
    vec_t v;
    v.wr = (wr != 0);  v.rd = (rd != 0);  v.r = 2'(r);  v.wd = wd;  v.rdy = (rdy != 0);
    v.eWait = (eW != 0);  v.eRdv = (eV != 0);  v.eRdata = eD;
    v.eOv = (eO != 0);  v.eOd = eOd;  v.eIrq = (eI != 0);
    return v;
  endfunction

  function automatic void modelReset();
    mq.delete();
    mIrqEn = 1'b0; mIrq = 1'b0; mPend = 1'b0;
    mThresh = 0; mAge = 0; mVal = '0; mRdata = '0;
  endfunction

  function automatic logic [31:0] modelReg(int r);
    logic [31:0] v;
    int sz;
    v  = '0;
    sz = mq.size();
    case (r)
      1: begin v[0] = (sz == 0); v[1] = (sz == DEPTH); v[8 +: CW] = CW'(sz); end
      2: begin v[1] = mIrqEn; v[8 +: CW] = CW'(mThresh); end
      3: if (sz > 0) v = mq[0];
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic modelWait(int wr, int r);
    return mPend || ((wr != 0) && (r == 0) && (mq.size() == DEPTH));
  endfunction

  // Advance the model across one rising edge with the inputs held during the cycle.
  function automatic void modelStep(int wr, int rd, int r, logic [31:0] wd, int rdy);
    int   sz;
    logic acc, irqNext;
    sz      = mq.size();
    acc     = ((wr != 0) || (rd != 0)) && !modelWait(wr, r);
    irqNext = mIrqEn && (sz >= mThresh) && (sz > 0);
    if (mPend) begin
      if (mAge == L) mPend = 1'b0;
      else mAge++;
    end
    if (acc && (rd != 0)) begin
      mVal  = modelReg(r);
      mPend = 1'b1;
      mAge  = 1;
    end
    if (acc && (wr != 0) && (r == 2)) begin
      mIrqEn  = wd[1];
      mThresh = int'(wd[8 +: CW]);
    end
    if (acc && (wr != 0) && (r == 2) && wd[0]) begin
      mq.delete();
    end else begin
      if ((sz > 0) && (rdy != 0)) void'(mq.pop_front());
      if (acc && (wr != 0) && (r == 0)) mq.push_back(wd);
    end
    mIrq = irqNext;
    if (mPend && (mAge == L)) mRdata = mVal;
  endfunction

  task automatic doReset();
    @(posedge clk);
    #1;
    reset_n = 1'b0; write = 1'b0; read = 1'b0; out_ready = 1'b0;
    address = '0; writedata = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    modelReset();
    @(negedge clk);
    checkFlag("reset waitrequest", waitrequest, 1'b0);
    checkFlag("reset readdatavalid", readdatavalid, 1'b0);
    checkOutput("reset readdata", readdata, 32'h0);
    checkFlag("reset out_valid", out_valid, 1'b0);
    checkOutput("reset out_data", out_data, 32'h0);
    checkFlag("reset irq", irq, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        hWr, hRd, rdy, holding, eWait;
    logic [1:0]  hR;
    logic [31:0] hWd;
    int          readyPct, p;

    reset_n = 1'b1; write = 1'b0; read = 1'b0; out_ready = 1'b0;
    address = '0; writedata = '0;

    // ---- cycle table: status read latency, small push/drain, head peek, control ----
    tbl[0]  = mk(0,0,0,0,0,        0,0,0,0,0,0);
    tbl[1]  = mk(0,1,1,0,0,        0,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,        1,0,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,        1,1,'h1,0,0,0);
    tbl[4]  = mk(0,0,0,0,0,        0,0,'h1,0,0,0);
    tbl[5]  = mk(1,0,0,'h11,0,     0,0,'h1,0,0,0);
    tbl[6]  = mk(1,0,0,'h22,0,     0,0,'h1,1,'h11,0);
    tbl[7]  = mk(1,0,0,'h33,0,     0,0,'h1,1,'h11,0);
    tbl[8]  = mk(0,1,1,0,0,        0,0,'h1,1,'h11,0);
    tbl[9]  = mk(0,0,0,0,0,        1,0,'h1,1,'h11,0);
    tbl[10] = mk(0,0,0,0,0,        1,1,'h300,1,'h11,0);
    tbl[11] = mk(0,1,3,0,0,        0,0,'h300,1,'h11,0);
    tbl[12] = mk(0,0,0,0,1,        1,0,'h300,1,'h11,0);
    tbl[13] = mk(0,0,0,0,1,        1,1,'h11,1,'h22,0);
    tbl[14] = mk(0,0,0,0,1,        0,0,'h11,1,'h33,0);
    tbl[15] = mk(0,1,3,0,1,        0,0,'h11,0,0,0);
    tbl[16] = mk(0,0,0,0,1,        1,0,'h11,0,0,0);
    tbl[17] = mk(0,0,0,0,0,        1,1,'h0,0,0,0);
    tbl[18] = mk(1,0,2,'h503,0,    0,0,'h0,0,0,0);
    tbl[19] = mk(0,1,2,0,0,        0,0,'h0,0,0,0);
    tbl[20] = mk(0,0,0,0,0,        1,0,'h0,0,0,0);
    tbl[21] = mk(0,0,0,0,0,        1,1,'h502,0,0,0);
    tbl[22] = mk(1,0,1,'hFFFFFFFF,0, 0,0,'h502,0,0,0);
    tbl[23] = mk(0,1,1,0,0,        0,0,'h502,0,0,0);
    tbl[24] = mk(0,0,0,0,0,        1,0,'h502,0,0,0);
    tbl[25] = mk(0,0,0,0,0,        1,1,'h1,0,0,0);

    doReset();
    for (int i = 0; i < 26; i++) begin
      applyStimulus(int'(tbl[i].wr), int'(tbl[i].rd), int'(tbl[i].r), tbl[i].wd, int'(tbl[i].rdy));
      checkFlag($sformatf("tbl[%0d] waitrequest", i), waitrequest, tbl[i].eWait);
      checkFlag($sformatf("tbl[%0d] readdatavalid", i), readdatavalid, tbl[i].eRdv);
      checkOutput($sformatf("tbl[%0d] readdata", i), readdata, tbl[i].eRdata);
      checkFlag($sformatf("tbl[%0d] out_valid", i), out_valid, tbl[i].eOv);
      if (tbl[i].eOv) checkOutput($sformatf("tbl[%0d] out_data", i), out_data, tbl[i].eOd);
      checkFlag($sformatf("tbl[%0d] irq", i), irq, tbl[i].eIrq);
    end

    // ---- fill to full, stall the 17th write, release it with a single pop ----
    doReset();
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1, 0, 0, 32'hA5A50000 + 32'(i), 0);
      checkFlag($sformatf("fill %0d waitrequest", i), waitrequest, 1'b0);
    end
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkFlag("full status rdv", readdatavalid, 1'b1);
    checkOutput("full status", readdata, 32'h00001002);
    applyStimulus(1, 0, 0, 32'hA5A50011, 0);
    checkFlag("full write stall a", waitrequest, 1'b1);
    applyStimulus(1, 0, 0, 32'hA5A50011, 0);
    checkFlag("full write stall b", waitrequest, 1'b1);
    applyStimulus(1, 0, 0, 32'hA5A50011, 1);
    checkFlag("stall holds during pop", waitrequest, 1'b1);
    checkOutput("popped head", out_data, 32'hA5A50001);
    applyStimulus(1, 0, 0, 32'hA5A50011, 0);
    checkFlag("write accepted after pop", waitrequest, 1'b0);
    checkOutput("head after pop", out_data, 32'hA5A50002);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("refilled status", readdata, 32'h00001002);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkFlag($sformatf("drain %0d out_valid", k), out_valid, 1'b1);
      checkOutput($sformatf("drain %0d out_data", k), out_data, 32'hA5A50002 + 32'(k));
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkFlag("drained out_valid", out_valid, 1'b0);

    // ---- interrupt threshold: rises after the third push, falls after one pop ----
    doReset();
    applyStimulus(1, 0, 2, 32'h00000302, 0);
    applyStimulus(1, 0, 0, 32'h1, 0);
    applyStimulus(1, 0, 0, 32'h2, 0);
    applyStimulus(1, 0, 0, 32'h3, 0);
    checkFlag("irq count2", irq, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkFlag("irq count3 not yet", irq, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkFlag("irq raised", irq, 1'b1);
    applyStimulus(0, 0, 0, 0, 1);
    checkFlag("irq during pop", irq, 1'b1);
    applyStimulus(0, 0, 0, 0, 0);
    checkFlag("irq one cycle after pop", irq, 1'b1);
    applyStimulus(0, 0, 0, 0, 0);
    checkFlag("irq cleared", irq, 1'b0);

    // ---- flush beats a concurrent pop and self-clears ----
    doReset();
    applyStimulus(1, 0, 2, 32'h00000302, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 32'hF0 + 32'(i), 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 2, 32'h00000303, 1);
    checkFlag("flush cycle out_valid", out_valid, 1'b1);
    checkFlag("flush cycle irq", irq, 1'b1);
    applyStimulus(0, 0, 0, 0, 1);
    checkFlag("after flush out_valid", out_valid, 1'b0);
    applyStimulus(0, 1, 1, 0, 0);
    checkFlag("after flush irq late", irq, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("after flush status", readdata, 32'h00000001);
    applyStimulus(0, 1, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("after flush control", readdata, 32'h00000302);

    // ---- reset while a read is pending drops the response ----
    doReset();
    applyStimulus(1, 0, 0, 32'hC0DE0001, 0);
    applyStimulus(0, 1, 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkFlag("head read rdv", readdatavalid, 1'b1);
    checkOutput("head read data", readdata, 32'hC0DE0001);
    applyStimulus(0, 1, 3, 0, 0);
    @(posedge clk);
    #1;
    read = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    checkFlag("pending read busy", waitrequest, 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkFlag("midread readdatavalid", readdatavalid, 1'b0);
    checkFlag("midread waitrequest", waitrequest, 1'b0);
    checkOutput("midread readdata", readdata, 32'h0);
    checkFlag("midread out_valid", out_valid, 1'b0);
    checkOutput("midread out_data", out_data, 32'h0);
    checkFlag("midread irq", irq, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkFlag("midread no late rdv", readdatavalid, 1'b0);

    // ---- randomized traffic against the queue model ----
    doReset();
    holding  = 1'b0;
    readyPct = 50;
    hWr = 1'b0; hRd = 1'b0; hR = 2'd0; hWd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) readyPct = $urandom_range(90, 10);
      if (!holding) begin
        p   = $urandom_range(99);
        hWr = 1'b0; hRd = 1'b0; hR = 2'd0; hWd = $urandom();
        if (p < 35) begin
          hWr = 1'b1;
        end else if (p < 50) begin
          hRd = 1'b1;
          hR  = 2'($urandom_range(3));
        end else if (p < 55) begin
          hWr = 1'b1;
          hR  = 2'd2;
          hWd[8 +: CW] = CW'($urandom_range(DEPTH));
          hWd[0] = ($urandom_range(3) == 0);
        end else if (p < 58) begin
          hWr = 1'b1;
          hR  = ($urandom_range(1) == 0) ? 2'd1 : 2'd3;
        end
      end
      rdy = ($urandom_range(99) < readyPct);
      applyStimulus(int'(hWr), int'(hRd), int'(hR), hWd, int'(rdy));
      eWait = modelWait(int'(hWr), int'(hR));
      checkFlag($sformatf("rnd %0d waitrequest", n), waitrequest, eWait);
      checkFlag($sformatf("rnd %0d readdatavalid", n), readdatavalid, mPend && (mAge == L));
      checkOutput($sformatf("rnd %0d readdata", n), readdata, mRdata);
      checkFlag($sformatf("rnd %0d out_valid", n), out_valid, mq.size() > 0);
      if (mq.size() > 0) checkOutput($sformatf("rnd %0d out_data", n), out_data, mq[0]);
      checkFlag($sformatf("rnd %0d irq", n), irq, mIrq);
      holding = (hWr || hRd) && eWait;
      modelStep(int'(hWr), int'(hRd), int'(hR), hWd, int'(rdy));
      if ($urandom_range(999) == 0) begin
        doReset();
        holding = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
